// File: rtl/seq_divider_pkg.sv
// seq_divider_pkg: shared bike-computer definitions for the sequential divider
//   state_e       : divider FSM encoding (IDLE, CALC, DONE)
//   DEFAULT_WIDTH : default operand/result width
package seq_divider_pkg;
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_e;
   localparam int DEFAULT_WIDTH = 16;
endpackage

// File: rtl/seq_divider.sv
// seq_divider: radix-2 restoring unsigned divider, one quotient bit per cycle
//   clk       in  : clock, rising edge
//   rst       in  : asynchronous active-high reset
//   start     in  : request a division (honoured in IDLE or DONE only)
//   dividend  in  : numerator, captured on an accepted start
//   divisor   in  : denominator, captured on an accepted start
//   busy      out : high while calculating
//   ready     out : high while the result is valid
//   quotient  out : registered quotient (all ones on divide by zero)
//   remainder out : registered remainder (dividend on divide by zero)
//   div_zero  out : high in DONE when the captured divisor was zero
module seq_divider
   import seq_divider_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             ready,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_zero
);
   localparam int CW = $clog2(WIDTH + 1);
   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
   logic [WIDTH-1:0] quotient_q, quotient_d, remainder_q, remainder_d;
   logic             div_zero_q, div_zero_d;
   logic [WIDTH:0]   shift_w, diff_w;
   logic             accept_w;
   // The shifted partial remainder needs one extra bit; the trial
   // subtraction is done at that width so its MSB is the borrow.
   always_comb begin
      shift_w     = {rem_q, quo_q[WIDTH-1]};
      diff_w      = shift_w - {1'b0, dvs_q};
      accept_w    = start && state_q != CALC;
      state_d     = state_q;
      cnt_d       = cnt_q;
      rem_d       = rem_q;
      quo_d       = quo_q;
      dvs_d       = dvs_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      div_zero_d  = div_zero_q;
      if (accept_w) begin
         state_d = CALC;
         cnt_d   = '0;
         rem_d   = '0;
         quo_d   = dividend;
         dvs_d   = divisor;
      end else if (state_q == CALC) begin
         rem_d = diff_w[WIDTH] ? shift_w[WIDTH-1:0] : diff_w[WIDTH-1:0];
         quo_d = {quo_q[WIDTH-2:0], ~diff_w[WIDTH]};
         cnt_d = cnt_q + CW'(1);
         if (cnt_q == CW'(WIDTH - 1)) begin
            state_d     = DONE;
            quotient_d  = quo_d;
            remainder_d = rem_d;
            div_zero_d  = dvs_q == '0;
         end
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         rem_q       <= '0;
         quo_q       <= '0;
         dvs_q       <= '0;
         quotient_q  <= '0;
         remainder_q <= '0;
         div_zero_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rem_q       <= rem_d;
         quo_q       <= quo_d;
         dvs_q       <= dvs_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
         div_zero_q  <= div_zero_d;
      end
   end
   assign busy      = state_q == CALC;
   assign ready     = state_q == DONE;
   assign quotient  = quotient_q;
   assign remainder = remainder_q;
   assign div_zero  = div_zero_q && state_q == DONE;
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed self-checking bench for seq_divider
module tb_seq_divider;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [15:0] dividend = '0;
   logic [15:0] divisor = '0;
   logic        busy, ready, div_zero;
   logic [15:0] quotient, remainder;
   int          checks = 0;
   int          passes = 0;

   seq_divider dut (
      .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
      .busy(busy), .ready(ready), .quotient(quotient), .remainder(remainder),
      .div_zero(div_zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      assert (got === want) passes++;
      else $error("FAIL %s: observed %0d expected %0d", tag, got, want);
   endtask

   // Launch a division and follow it to DONE; pulse_at injects a 5/5 start
   // request that many cycles into CALC (0 = none).
   task automatic run(input string tag, input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] eq, input logic [15:0] er, input logic ez,
                      input int pulse_at);
      logic [15:0] pq, pr;
      int          n;
      bit          moved, both;
      @(negedge clk);
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      pq = quotient;
      pr = remainder;
      chk({tag, " busy_on_accept"}, 32'(busy), 1);
      chk({tag, " ready_drop_on_accept"}, 32'(ready), 0);
      n = 1;
      moved = 1'b0;
      both = 1'b0;
      while (busy && n < 100) begin
         if (n == pulse_at) begin
            dividend = 16'd5;
            divisor  = 16'd5;
            start    = 1'b1;
         end
         @(posedge clk);
         #1 start = 1'b0;
         if (busy && (quotient !== pq || remainder !== pr)) moved = 1'b1;
         if (busy && ready) both = 1'b1;
         n++;
      end
      chk({tag, " busy_cycles"}, 32'(n - 1), 16);
      chk({tag, " outputs_frozen_in_calc"}, 32'(moved), 0);
      chk({tag, " busy_ready_exclusive"}, 32'(both), 0);
      chk({tag, " ready"}, 32'(ready), 1);
      chk({tag, " quotient"}, 32'(quotient), 32'(eq));
      chk({tag, " remainder"}, 32'(remainder), 32'(er));
      chk({tag, " div_zero"}, 32'(div_zero), 32'(ez));
   endtask

   initial begin
      #12;
      chk("reset busy", 32'(busy), 0);
      chk("reset ready", 32'(ready), 0);
      chk("reset quotient", 32'(quotient), 0);
      chk("reset remainder", 32'(remainder), 0);
      chk("reset div_zero", 32'(div_zero), 0);
      @(negedge clk);
      rst = 1'b0;
      run("1000/7", 16'd1000, 16'd7, 16'd142, 16'd6, 1'b0, 0);
      run("b2b 100/10", 16'd100, 16'd10, 16'd10, 16'd0, 1'b0, 0);
      repeat (3) @(posedge clk);
      #1;
      chk("done_hold ready", 32'(ready), 1);
      chk("done_hold quotient", 32'(quotient), 10);
      chk("done_hold remainder", 32'(remainder), 0);
      run("1234/0", 16'd1234, 16'd0, 16'hFFFF, 16'd1234, 1'b1, 0);
      run("60000/3 pulse", 16'd60000, 16'd3, 16'd20000, 16'd0, 1'b0, 8);
      run("5/65535", 16'd5, 16'd65535, 16'd0, 16'd5, 1'b0, 0);
      @(negedge clk);
      dividend = 16'd500;
      divisor  = 16'd3;
      start    = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (4) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      chk("abort busy", 32'(busy), 0);
      chk("abort ready", 32'(ready), 0);
      chk("abort quotient", 32'(quotient), 0);
      chk("abort remainder", 32'(remainder), 0);
      chk("abort div_zero", 32'(div_zero), 0);
      repeat (2) @(posedge clk);
      #1;
      chk("abort no_ready_pulse", 32'(ready), 0);
      @(negedge clk);
      rst = 1'b0;
      run("9/4 after abort", 16'd9, 16'd4, 16'd2, 16'd1, 1'b0, 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
